// File: rtl/uint8.sv
// Purpose : registered 8-bit unsigned hop between neighbouring systolic PEs, with valid tracking.
// Latency : exactly DEPTH enabled clock cycles from u8_in to u8_out (DEPTH = 1..16).
// Backpressure: en=0 stalls every stage in place (data and valid); nothing is dropped or forced.
//
// Ports:
//   clk       rising-edge clock, sole clock domain
//   rst_n     asynchronous active-low reset; clears every stage, u8_out and out_valid
//   en        stage enable; 0 holds all stages
//   in_valid  u8_in carries a valid sample this cycle
//   u8_in     unsigned byte in, bit 0 = MSB
//   u8_out    unsigned byte out, same bit ordering, straight from the last stage
//   out_valid u8_out carries a valid sample
module uint8 #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [0:7] u8_in,
  output logic [0:7] u8_out,
  output logic       out_valid
);

  // One pipeline slot: the valid flag travels alongside its byte so that a
  // stall freezes both together and they can never drift apart.
  typedef struct packed {
    logic       valid;
    logic [0:7] data;
  } stage_t;

  // Reject illegal depths at elaboration rather than building a broken pipe.
  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
    $error("uint8: DEPTH must be in 1..16");
  end

  stage_t pipe [DEPTH];

  // Data is captured regardless of in_valid; only the flag marks validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe[k] <= '0;
      end
    end else if (en) begin
      pipe[0] <= '{valid: in_valid, data: u8_in};
      for (int k = 1; k < DEPTH; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  // Outputs are pure register outputs: no combinational path from any input.
  assign u8_out    = pipe[DEPTH-1].data;
  assign out_valid = pipe[DEPTH-1].valid;

endmodule

// File: tb/tb_uint8.sv
module tb_uint8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [0:7] u8_in;
  logic [0:7] out1;
  logic       vld1;
  logic [0:7] out3;
  logic       vld3;

  int checks = 0;
  int passed = 0;
  bit chk_on = 0;

  uint8 #(.DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .u8_in(u8_in), .u8_out(out1), .out_valid(vld1)
  );

  uint8 #(.DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .u8_in(u8_in), .u8_out(out3), .out_valid(vld3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of everything the stage accepted on enabled
  // edges, newest first. A depth-D stage shows the sample accepted D enabled
  // edges ago, or zero if fewer than D samples arrived since reset.
  logic [8:0] hist [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
    end else if (en) begin
      hist.push_front({in_valid, u8_in});
      if (hist.size() > 16) void'(hist.pop_back());
    end
  end

  function automatic logic [8:0] model_out(input int d);
    if (hist.size() >= d) return hist[d-1];
    return 9'd0;
  endfunction

  // Continuous comparison on the opposite clock edge.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [8:0] e1;
      logic [8:0] e3;
      e1 = model_out(1);
      e3 = model_out(3);
      check("d1_data",  32'(out1), 32'(e1[7:0]));
      check("d1_valid", 32'(vld1), 32'(e1[8]));
      check("d3_data",  32'(out3), 32'(e3[7:0]));
      check("d3_valid", 32'(vld3), 32'(e3[8]));
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [0:7] v;
    logic [7:0] range_vals [4];
    range_vals[0] = 8'd0;
    range_vals[1] = 8'd1;
    range_vals[2] = 8'd128;
    range_vals[3] = 8'd255;

    // Reset held with hostile inputs.
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b1;
    u8_in    = 8'hFF;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_d1_data",  32'(out1), 32'd0);
      check("rst_d1_valid", 32'(vld1), 32'd0);
      check("rst_d3_data",  32'(out3), 32'd0);
      check("rst_d3_valid", 32'(vld3), 32'd0);
    end
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Stall: 42 loaded, then held while the input shows 7.
    u8_in = 8'd42;
    tick();
    check("stall_load", 32'(out1), 32'd42);
    en    = 1'b0;
    u8_in = 8'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 32'(out1), 32'd42);
    end
    en = 1'b1;
    tick();
    check("stall_release", 32'(out1), 32'd7);

    // Range and bit order.
    for (int i = 0; i < 4; i++) begin
      u8_in = range_vals[i];
      tick();
      check("range", 32'(out1), 32'(range_vals[i]));
      if (i == 2) check("msb_bit0", 32'(out1[0]), 32'd1);
    end

    // Ramp with inputs moving every 15 units against a 20-unit clock;
    // the negedge checker confirms only edge-sampled values appear.
    for (int i = 0; i < 10; i++) begin
      u8_in = 8'(i);
      #15;
    end
    tick();

    // Randomised stream with random stalls.
    for (int i = 0; i < 200; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1);
      u8_in    = 8'($urandom);
      tick();
    end

    // Asynchronous reset between edges, mid-stream.
    en       = 1'b1;
    in_valid = 1'b1;
    u8_in    = 8'hA5;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #2;
    check("arst_d1_data",  32'(out1), 32'd0);
    check("arst_d1_valid", 32'(vld1), 32'd0);
    check("arst_d3_data",  32'(out3), 32'd0);
    check("arst_d3_valid", 32'(vld3), 32'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_after_rst", 32'(vld3), 32'd0);
    end

    // Latency: a single valid 200 surfaces exactly 3 enabled edges later for one cycle.
    in_valid = 1'b1;
    u8_in    = 8'd200;
    for (int i = 1; i <= 4; i++) begin
      tick();
      in_valid = 1'b0;
      v        = 8'($urandom_range(0, 199));
      u8_in    = v;
      check("lat_valid", 32'(vld3), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check("lat_data", 32'(out3), 32'd200);
    end

    tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
